// File: rtl/i2c_slave_rx.sv
// Write-only I2C target receiver: oversamples SCL/SDA, detects START/STOP,
// matches a 7-bit address, ACKs every byte and emits received bytes as pulses.
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       busy,
    output logic       stop_det
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic [3:0]             bit_cnt;
    logic [7:0]             shift;

    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_ev, stop_ev;

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    // SCL must be high in both samples so an SCL edge coinciding with an
    // SDA edge is never mistaken for a bus condition.
    assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;

    // Input synchronizers plus one delayed copy for edge detection; reset to idle-bus level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    // Protocol FSM; bus conditions override bit-level activity in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            shift      <= 8'h00;
            sda_oe     <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            addr_match <= 1'b0;
            busy       <= 1'b0;
            stop_det   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            stop_det <= 1'b0;
            if (stop_ev) begin
                state      <= IDLE;
                bit_cnt    <= 4'd0;
                sda_oe     <= 1'b0;
                addr_match <= 1'b0;
                busy       <= 1'b0;
                stop_det   <= 1'b1;
            end else if (start_ev) begin
                state      <= ADDR;
                bit_cnt    <= 4'd0;
                sda_oe     <= 1'b0;
                addr_match <= 1'b0;
                busy       <= 1'b1;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            // Only a write to our address is ACKed; reads are NACKed.
                            if (shift[7:1] == SLAVE_ADDR && !shift[0]) begin
                                sda_oe     <= 1'b1;
                                addr_match <= 1'b1;
                                state      <= ADDR_ACK;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK, DATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= DATA;
                        end
                    end
                    DATA: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            sda_oe   <= 1'b1;
                            bit_cnt  <= 4'd0;
                            state    <= DATA_ACK;
                        end
                    end
                    default: ;  // IDLE and IGNORE only react to START/STOP
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: a bit-banged master drives SCL = clk/16,
// SDA is modelled as a wired-AND of master and target pull-down.
module tb_i2c_slave_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       busy;
    logic       stop_det;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rx_q[$];
    int         stop_cnt = 0;
    logic       ack;

    assign sda_bus = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_in     (scl),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .addr_match (addr_match),
        .busy       (busy),
        .stop_det   (stop_det)
    );

    // Collect delivered bytes and STOP pulses away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (stop_det) stop_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(posedge clk);
    endtask

    // START or repeated START; leaves SCL low.
    task automatic start_cond();
        m_sda = 1'b1; wt(4);
        scl = 1'b1;   wt(4);
        m_sda = 1'b0; wt(4);
        scl = 1'b0;
    endtask

    // STOP from SCL low; leaves bus idle.
    task automatic stop_cond();
        wt(4); m_sda = 1'b0; wt(4);
        scl = 1'b1;   wt(4);
        m_sda = 1'b1; wt(8);
    endtask

    task automatic send_bit(input logic b);
        wt(4); m_sda = b; wt(4);
        scl = 1'b1; wt(8);
        scl = 1'b0;
    endtask

    // Eight data bits MSB first, then an ACK slot with SDA released by the master.
    task automatic send_byte(input logic [7:0] v, output logic a);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        wt(4); m_sda = 1'b1; wt(4);
        scl = 1'b1; wt(4);
        @(negedge clk) a = sda_oe;
        wt(4);
        scl = 1'b0;
    endtask

    initial begin
        // Reset
        wt(2);
        @(negedge clk);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 0);
        rst_n = 1'b1; wt(4);

        // Write 0x50, data A5, 3C, STOP
        start_cond();
        send_byte(8'hA0, ack); chk("f1_addr_ack", ack, 1);
        chk("f1_addr_match", addr_match, 1);
        chk("f1_busy", busy, 1);
        send_byte(8'hA5, ack); chk("f1_d0_ack", ack, 1);
        send_byte(8'h3C, ack); chk("f1_d1_ack", ack, 1);
        stop_cond();
        chk("f1_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            chk("f1_rx0", rx_q[0], 8'hA5);
            chk("f1_rx1", rx_q[1], 8'h3C);
        end
        chk("f1_stop_cnt", stop_cnt, 1);
        chk("f1_busy_end", busy, 0);
        chk("f1_match_end", addr_match, 0);
        rx_q.delete(); wt(8);

        // Write to 0x51: not ours
        start_cond();
        send_byte(8'hA2, ack); chk("f2_addr_nack", ack, 0);
        send_byte(8'h55, ack); chk("f2_data_nack", ack, 0);
        chk("f2_addr_match", addr_match, 0);
        chk("f2_busy", busy, 1);
        stop_cond();
        chk("f2_rx_count", rx_q.size(), 0);
        chk("f2_busy_end", busy, 0);
        chk("f2_stop_cnt", stop_cnt, 2);
        rx_q.delete(); wt(8);

        // Read from 0x50: NACKed, ignored
        start_cond();
        send_byte(8'hA1, ack); chk("f3_read_nack", ack, 0);
        chk("f3_addr_match", addr_match, 0);
        send_byte(8'hFF, ack); chk("f3_data_nack", ack, 0);
        stop_cond();
        chk("f3_rx_count", rx_q.size(), 0);
        rx_q.delete(); wt(8);

        // Repeated START after 4 data bits
        start_cond();
        send_byte(8'hA0, ack); chk("f4_addr_ack0", ack, 1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        start_cond();
        chk("f4_rs_match", addr_match, 0);
        chk("f4_rs_oe", sda_oe, 0);
        send_byte(8'hA0, ack); chk("f4_addr_ack1", ack, 1);
        send_byte(8'h81, ack); chk("f4_d_ack", ack, 1);
        stop_cond();
        chk("f4_rx_count", rx_q.size(), 1);
        if (rx_q.size() == 1) chk("f4_rx0", rx_q[0], 8'h81);
        rx_q.delete(); wt(8);

        // Reset during the data ACK slot
        start_cond();
        send_byte(8'hA0, ack); chk("f5_addr_ack", ack, 1);
        for (int i = 7; i >= 0; i--) send_bit(1'b0);
        wt(4); m_sda = 1'b1; wt(4);
        scl = 1'b1; wt(4);
        @(negedge clk);
        chk("f5_ack_slot_oe", sda_oe, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("f5_rst_oe", sda_oe, 0);
        chk("f5_rst_busy", busy, 0);
        rst_n = 1'b1;
        wt(8);
        rx_q.delete();

        // Full frame after reset
        start_cond();
        send_byte(8'hA0, ack); chk("f6_addr_ack", ack, 1);
        send_byte(8'hA5, ack); chk("f6_d_ack", ack, 1);
        stop_cond();
        chk("f6_rx_count", rx_q.size(), 1);
        if (rx_q.size() == 1) chk("f6_rx0", rx_q[0], 8'hA5);
        chk("f6_busy_end", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
